// File: rtl/cu_pkg.sv
// Shared types and encodings for the multi-cycle control unit.
// Opcodes, ALU function codes, PC source selects and FSM states.
package cu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_e;

    typedef enum logic [3:0] {
        CL_ALU,
        CL_LB,
        CL_LW,
        CL_SW,
        CL_BEQ,
        CL_BLT,
        CL_BGT,
        CL_JMP,
        CL_HALT
    } class_e;

    localparam logic [3:0] OP_HALT  = 4'b0000;
    localparam logic [3:0] OP_JMP   = 4'b0001;
    localparam logic [3:0] OP_BLT   = 4'b0100;
    localparam logic [3:0] OP_BEQ   = 4'b0101;
    localparam logic [3:0] OP_BGT   = 4'b0110;
    localparam logic [3:0] OP_ANDI  = 4'b1000;
    localparam logic [3:0] OP_ORI   = 4'b1001;
    localparam logic [3:0] OP_ADDI  = 4'b1010;
    localparam logic [3:0] OP_LB    = 4'b1011;
    localparam logic [3:0] OP_LW    = 4'b1100;
    localparam logic [3:0] OP_SW    = 4'b1101;
    localparam logic [3:0] OP_RTYPE = 4'b1111;

    localparam logic [3:0] FC_ADD = 4'b0000;
    localparam logic [3:0] FC_CMP = 4'b0001;
    localparam logic [3:0] FC_AND = 4'b0100;
    localparam logic [3:0] FC_OR  = 4'b0101;
    localparam logic [3:0] FC_SLT = 4'b0111;
    localparam logic [3:0] FC_SHL = 4'b1000;

    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;

endpackage

// File: rtl/cu_decode.sv
// Combinational instruction decoder: opcode/fc to instruction class,
// ALU controls and a legality flag.
import cu_pkg::*;

module cu_decode #(
    parameter int INSTR_W = 16,
    parameter int FC_W    = 4
) (
    input  logic [INSTR_W-1:0] instr,
    output class_e             cls,
    output logic [FC_W-1:0]    alu_fc,
    output logic               alu_imm,
    output logic               imm_sext,
    output logic               legal
);

    logic [3:0]      op;
    logic [FC_W-1:0] fc;
    logic            fc_ok;
    logic            unused_instr;

    assign op = instr[INSTR_W-1 -: 4];
    assign fc = instr[FC_W-1:0];
    assign unused_instr = ^instr;

    assign fc_ok = (fc == FC_W'(FC_ADD)) || (fc == FC_W'(FC_CMP)) ||
                   (fc == FC_W'(FC_AND)) || (fc == FC_W'(FC_OR))  ||
                   (fc == FC_W'(FC_SLT)) || (fc == FC_W'(FC_SHL));

    always_comb begin
        cls      = CL_HALT;
        alu_fc   = '0;
        alu_imm  = 1'b0;
        imm_sext = 1'b0;
        legal    = 1'b1;
        unique case (op)
            OP_RTYPE: begin
                cls    = CL_ALU;
                alu_fc = fc;
                legal  = fc_ok;
            end
            OP_ANDI: begin
                cls     = CL_ALU;
                alu_fc  = FC_W'(FC_AND);
                alu_imm = 1'b1;
            end
            OP_ORI: begin
                cls     = CL_ALU;
                alu_fc  = FC_W'(FC_OR);
                alu_imm = 1'b1;
            end
            OP_ADDI: begin
                cls      = CL_ALU;
                alu_fc   = FC_W'(FC_ADD);
                alu_imm  = 1'b1;
                imm_sext = 1'b1;
            end
            OP_LB, OP_LW, OP_SW: begin
                cls      = (op == OP_LB) ? CL_LB :
                           (op == OP_LW) ? CL_LW : CL_SW;
                alu_fc   = FC_W'(FC_ADD);
                alu_imm  = 1'b1;
                imm_sext = 1'b1;
            end
            OP_BEQ, OP_BLT, OP_BGT: begin
                cls    = (op == OP_BEQ) ? CL_BEQ :
                         (op == OP_BLT) ? CL_BLT : CL_BGT;
                alu_fc = FC_W'(FC_CMP);
            end
            OP_JMP:  cls = CL_JMP;
            OP_HALT: cls = CL_HALT;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/cu_mc.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with
// memory timeout and sticky halt/trap flags.
import cu_pkg::*;

module cu_mc #(
    parameter int INSTR_W     = 16,
    parameter int FC_W        = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] instr,
    input  logic               mem_ready,
    input  logic [3:0]         cmp_flags,
    output logic               mem_req,
    output logic               mem_we,
    output logic               mem_byte,
    output logic               ir_write,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic [FC_W-1:0]    alu_fc,
    output logic               alu_imm,
    output logic               imm_sext,
    output logic               reg_write,
    output logic               wb_sel,
    output logic               halted,
    output logic               trap
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    state_e          state_q, state_d;
    class_e          cls_q, cls_d;
    logic [FC_W-1:0] fc_q, fc_d;
    logic            imm_q, imm_d;
    logic            sext_q, sext_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            halted_q, halted_d;
    logic            trap_q, trap_d;

    class_e          dec_cls;
    logic [FC_W-1:0] dec_fc;
    logic            dec_imm;
    logic            dec_sext;
    logic            dec_legal;

    logic [CNT_W-1:0] cnt_inc;
    logic            timeout;
    logic            take;
    logic            unused_zero;

    cu_decode #(
        .INSTR_W (INSTR_W),
        .FC_W    (FC_W)
    ) u_decode (
        .instr    (instr),
        .cls      (dec_cls),
        .alu_fc   (dec_fc),
        .alu_imm  (dec_imm),
        .imm_sext (dec_sext),
        .legal    (dec_legal)
    );

    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign timeout     = (cnt_inc == CNT_W'(MEM_TIMEOUT));
    assign unused_zero = cmp_flags[0];

    // cmp_flags = {lt, gt, eq, zero}
    assign take = ((cls_q == CL_BEQ) && cmp_flags[1]) ||
                  ((cls_q == CL_BLT) && cmp_flags[3]) ||
                  ((cls_q == CL_BGT) && cmp_flags[2]);

    always_comb begin
        state_d  = state_q;
        cls_d    = cls_q;
        fc_d     = fc_q;
        imm_d    = imm_q;
        sext_d   = sext_q;
        cnt_d    = cnt_q;
        halted_d = halted_q;
        trap_d   = trap_q;
        unique case (state_q)
            ST_FETCH, ST_MEM: begin
                if (mem_ready) begin
                    cnt_d = '0;
                    if (state_q == ST_FETCH)
                        state_d = ST_DECODE;
                    else if (cls_q == CL_SW)
                        state_d = ST_FETCH;
                    else
                        state_d = ST_WB;
                end else begin
                    cnt_d = cnt_inc;
                    if (timeout) begin
                        state_d = ST_HALT;
                        trap_d  = 1'b1;
                    end
                end
            end
            ST_DECODE: begin
                cls_d  = dec_cls;
                fc_d   = dec_fc;
                imm_d  = dec_imm;
                sext_d = dec_sext;
                if (!dec_legal) begin
                    state_d = ST_HALT;
                    trap_d  = 1'b1;
                end else if (dec_cls == CL_HALT) begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                cnt_d = '0;
                unique case (cls_q)
                    CL_ALU:               state_d = ST_WB;
                    CL_LB, CL_LW, CL_SW:  state_d = ST_MEM;
                    default:              state_d = ST_FETCH;
                endcase
            end
            ST_WB: begin
                cnt_d   = '0;
                state_d = ST_FETCH;
            end
            default: state_d = ST_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_FETCH;
            cls_q    <= CL_HALT;
            fc_q     <= '0;
            imm_q    <= 1'b0;
            sext_q   <= 1'b0;
            cnt_q    <= '0;
            halted_q <= 1'b0;
            trap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cls_q    <= cls_d;
            fc_q     <= fc_d;
            imm_q    <= imm_d;
            sext_q   <= sext_d;
            cnt_q    <= cnt_d;
            halted_q <= halted_d;
            trap_q   <= trap_d;
        end
    end

    // Strobes are forced low while reset is held so a stalled request
    // or write cannot leak past an asynchronous reset.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_byte  = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = PC_INC;
        alu_fc    = '0;
        alu_imm   = 1'b0;
        imm_sext  = 1'b0;
        reg_write = 1'b0;
        wb_sel    = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        pc_src   = PC_INC;
                    end
                end
                ST_EXEC: begin
                    alu_fc   = fc_q;
                    alu_imm  = imm_q;
                    imm_sext = sext_q;
                    if (cls_q == CL_JMP) begin
                        pc_write = 1'b1;
                        pc_src   = PC_JMP;
                    end else if (take) begin
                        pc_write = 1'b1;
                        pc_src   = PC_BR;
                    end
                end
                ST_MEM: begin
                    mem_req  = 1'b1;
                    mem_we   = (cls_q == CL_SW);
                    mem_byte = (cls_q == CL_LB);
                end
                ST_WB: begin
                    reg_write = 1'b1;
                    wb_sel    = (cls_q == CL_LB) || (cls_q == CL_LW);
                end
                default: ;
            endcase
        end
    end

    assign halted = halted_q;
    assign trap   = trap_q;

endmodule

// File: tb/tb_cu_mc.sv
// Directed testbench for cu_mc: per-scenario tasks with hand-computed
// output vectors sampled one time unit after the falling edge.
`timescale 1ns/1ps

module tb_cu_mc;

    logic        clk;
    logic        rst_n;
    logic [15:0] instr;
    logic        mem_ready;
    logic [3:0]  cmp_flags;
    logic        mem_req, mem_we, mem_byte, ir_write, pc_write;
    logic [1:0]  pc_src;
    logic [3:0]  alu_fc;
    logic        alu_imm, imm_sext, reg_write, wb_sel, halted, trap;

    int checks = 0;
    int failures = 0;

    // Output vector layout:
    // {mem_req, mem_we, mem_byte, ir_write, pc_write, pc_src[1:0],
    //  reg_write, wb_sel, alu_imm, imm_sext, alu_fc[3:0], halted, trap}
    localparam logic [16:0] REQ = 17'h10000;
    localparam logic [16:0] WE  = 17'h08000;
    localparam logic [16:0] BYT = 17'h04000;
    localparam logic [16:0] IRW = 17'h02000;
    localparam logic [16:0] PCW = 17'h01000;
    localparam logic [16:0] SJ  = 17'h00800;
    localparam logic [16:0] SBR = 17'h00400;
    localparam logic [16:0] RW  = 17'h00200;
    localparam logic [16:0] WBS = 17'h00100;
    localparam logic [16:0] IMM = 17'h00080;
    localparam logic [16:0] SXT = 17'h00040;
    localparam logic [16:0] HLT = 17'h00002;
    localparam logic [16:0] TRP = 17'h00001;
    localparam logic [16:0] NON = 17'h00000;
    localparam logic [16:0] FCH = REQ | IRW | PCW;

    cu_mc dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .instr     (instr),
        .mem_ready (mem_ready),
        .cmp_flags (cmp_flags),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_byte  (mem_byte),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .pc_src    (pc_src),
        .alu_fc    (alu_fc),
        .alu_imm   (alu_imm),
        .imm_sext  (imm_sext),
        .reg_write (reg_write),
        .wb_sel    (wb_sel),
        .halted    (halted),
        .trap      (trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] fcv(input logic [3:0] f);
        return {11'b0, f, 2'b00};
    endfunction

    function automatic logic [16:0] outs();
        return {mem_req, mem_we, mem_byte, ir_write, pc_write, pc_src,
                reg_write, wb_sel, alu_imm, imm_sext, alu_fc, halted, trap};
    endfunction

    task automatic cyc(input logic r, input logic [15:0] ins,
                       input logic [3:0] f);
        @(negedge clk);
        mem_ready = r;
        instr     = ins;
        cmp_flags = f;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mem_ready = 1'b1;
        instr = 16'h0000;
        cmp_flags = 4'h0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (outs() !== NON) begin
            failures++;
            $display("FAIL reset_outs: got %h want %h", outs(), NON);
        end
        mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 16'h0000, 4'h0);
        checks++;
        if (outs() !== REQ) begin
            failures++;
            $display("FAIL reset_fetch: got %h want %h", outs(), REQ);
        end
    endtask

    task automatic test_addi();
        logic [16:0] e [5];
        bit r [5];
        e = '{FCH, NON, IMM | SXT | fcv(4'h0), RW, REQ};
        r = '{1, 0, 0, 0, 0};
        for (int i = 0; i < 5; i++) begin
            cyc(r[i], 16'hA005, 4'h0);
            checks++;
            if (outs() !== e[i]) begin
                failures++;
                $display("FAIL addi[%0d]: got %h want %h", i, outs(), e[i]);
            end
        end
    endtask

    task automatic test_lw_stall();
        logic [16:0] e [9];
        bit r [9];
        e = '{FCH, NON, IMM | SXT | fcv(4'h0), REQ, REQ, REQ, REQ,
              RW | WBS, REQ};
        r = '{1, 0, 0, 0, 0, 0, 1, 0, 0};
        for (int i = 0; i < 9; i++) begin
            cyc(r[i], 16'hC123, 4'h0);
            checks++;
            if (outs() !== e[i]) begin
                failures++;
                $display("FAIL lw[%0d]: got %h want %h", i, outs(), e[i]);
            end
        end
    endtask

    task automatic test_branch();
        logic [16:0] e [16];
        logic [15:0] ins [16];
        logic [3:0]  f [16];
        bit r [16];
        ins = '{16'h5000, 16'h5000, 16'h5000, 16'h5000, 16'h5000, 16'h5000,
                16'h4000, 16'h4000, 16'h4000, 16'h6000, 16'h6000, 16'h6000,
                16'h1000, 16'h1000, 16'h1000, 16'h1000};
        f = '{4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'hC,
              4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h8,
              4'h0, 4'h0, 4'h0, 4'h0};
        r = '{1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0};
        e = '{FCH, NON, PCW | SBR | fcv(4'h1),
              FCH, NON, fcv(4'h1),
              FCH, NON, PCW | SBR | fcv(4'h1),
              FCH, NON, fcv(4'h1),
              FCH, NON, PCW | SJ, REQ};
        for (int i = 0; i < 16; i++) begin
            cyc(r[i], ins[i], f[i]);
            checks++;
            if (outs() !== e[i]) begin
                failures++;
                $display("FAIL branch[%0d]: got %h want %h", i, outs(), e[i]);
            end
        end
    endtask

    task automatic test_alu_lb();
        logic [16:0] e [18];
        logic [15:0] ins [18];
        bit r [18];
        ins = '{16'h8000, 16'h8000, 16'h8000, 16'h8000,
                16'h9005, 16'h9005, 16'h9005, 16'h9005,
                16'hF007, 16'hF007, 16'hF007, 16'hF007,
                16'hB000, 16'hB000, 16'hB000, 16'hB000, 16'hB000, 16'hB000};
        r = '{1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0};
        e = '{FCH, NON, IMM | fcv(4'h4), RW,
              FCH, NON, IMM | fcv(4'h5), RW,
              FCH, NON, fcv(4'h7), RW,
              FCH, NON, IMM | SXT | fcv(4'h0), REQ | BYT, RW | WBS, REQ};
        for (int i = 0; i < 18; i++) begin
            cyc(r[i], ins[i], 4'h0);
            checks++;
            if (outs() !== e[i]) begin
                failures++;
                $display("FAIL alu_lb[%0d]: got %h want %h", i, outs(), e[i]);
            end
        end
    endtask

    task automatic test_illegal();
        cyc(1'b1, 16'hF003, 4'h0);
        checks++;
        if (outs() !== FCH) begin
            failures++;
            $display("FAIL illegal_fetch: got %h want %h", outs(), FCH);
        end
        cyc(1'b0, 16'hF003, 4'h0);
        checks++;
        if (outs() !== NON) begin
            failures++;
            $display("FAIL illegal_decode: got %h want %h", outs(), NON);
        end
        for (int i = 0; i < 20; i++) begin
            cyc(1'(i % 2), 16'hA005, 4'hF);
            checks++;
            if (outs() !== TRP) begin
                failures++;
                $display("FAIL illegal_halt[%0d]: got %h want %h",
                         i, outs(), TRP);
            end
        end
    endtask

    task automatic test_timeout();
        @(negedge clk);
        rst_n = 1'b0;
        mem_ready = 1'b0;
        #1;
        checks++;
        if (outs() !== NON) begin
            failures++;
            $display("FAIL trap_clear: got %h want %h", outs(), NON);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (outs() !== REQ) begin
            failures++;
            $display("FAIL tmo_cycle1: got %h want %h", outs(), REQ);
        end
        for (int i = 2; i <= 15; i++) begin
            cyc(1'b0, 16'h0000, 4'h0);
            checks++;
            if (outs() !== REQ) begin
                failures++;
                $display("FAIL tmo_cycle%0d: got %h want %h", i, outs(), REQ);
            end
        end
        cyc(1'b0, 16'h0000, 4'h0);
        checks++;
        if (outs() !== TRP) begin
            failures++;
            $display("FAIL tmo_cycle16: got %h want %h", outs(), TRP);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (outs() !== NON) begin
            failures++;
            $display("FAIL tmo_async_clear: got %h want %h", outs(), NON);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 16'h0000, 4'h0);
        checks++;
        if (outs() !== REQ) begin
            failures++;
            $display("FAIL tmo_resume: got %h want %h", outs(), REQ);
        end
    endtask

    task automatic test_halt();
        logic [16:0] e [5];
        bit r [5];
        e = '{FCH, NON, HLT, HLT, HLT};
        r = '{1, 0, 1, 0, 1};
        for (int i = 0; i < 5; i++) begin
            cyc(r[i], 16'h0000, 4'h0);
            checks++;
            if (outs() !== e[i]) begin
                failures++;
                $display("FAIL halt[%0d]: got %h want %h", i, outs(), e[i]);
            end
        end
    endtask

    task automatic test_sw_reset();
        logic [16:0] e [10];
        bit r [10];
        @(negedge clk);
        rst_n = 1'b0;
        mem_ready = 1'b0;
        #1;
        checks++;
        if (outs() !== NON) begin
            failures++;
            $display("FAIL halt_clear: got %h want %h", outs(), NON);
        end
        @(negedge clk);
        rst_n = 1'b1;
        e = '{FCH, NON, IMM | SXT | fcv(4'h0), REQ | WE, REQ,
              FCH, NON, IMM | SXT | fcv(4'h0), REQ | WE, REQ | WE};
        r = '{1, 0, 0, 1, 0, 1, 0, 0, 0, 0};
        for (int i = 0; i < 10; i++) begin
            cyc(r[i], 16'hD000, 4'h0);
            checks++;
            if (outs() !== e[i]) begin
                failures++;
                $display("FAIL sw[%0d]: got %h want %h", i, outs(), e[i]);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_we, reg_write} !== 3'b000) begin
            failures++;
            $display("FAIL sw_reset_drop: got %b want 000",
                     {mem_req, mem_we, reg_write});
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 16'h0000, 4'h0);
        checks++;
        if (outs() !== REQ) begin
            failures++;
            $display("FAIL sw_reset_fetch: got %h want %h", outs(), REQ);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_lw_stall();
        test_branch();
        test_alu_lb();
        test_illegal();
        test_timeout();
        test_halt();
        test_sw_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
